// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam int          DEFAULT_XLEN     = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
    localparam int          DEFAULT_FQ_DEPTH = 4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instruction, pc} entries with flush.
// The head entry is presented combinationally and reads as zero when empty.
module fetch_queue #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok, pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !full;

    assign head_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding 64-bit memory read at a time, 32-bit
// instructions pushed into a small queue, redirect flushes and restarts.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int             XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int             FQ_DEPTH = DEFAULT_FQ_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [63:0]     mem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int QW = 32 + XLEN;

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] req_pc_reg, req_pc_next;
    logic            push, handshake, q_full, q_empty;
    logic [31:0]     resp_word;
    logic [QW-1:0]   head_data;

    assign mem_req_valid = (state_reg == ST_REQ) && !q_full && !reset;
    assign mem_req_addr  = {fetch_pc_reg[XLEN-1:3], 3'b000};
    assign handshake     = mem_req_valid && mem_req_ready;
    assign resp_word     = req_pc_reg[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_REQ;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        push          = 1'b0;
        case (state_reg)
            ST_REQ: begin
                if (handshake) begin
                    req_pc_next = fetch_pc_reg;
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    push          = 1'b1;
                    fetch_pc_next = req_pc_reg + XLEN'(4);
                    state_next    = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (mem_resp_valid) state_next = ST_REQ;
            end
            default: state_next = ST_REQ;
        endcase
        // A redirect discards any in-flight data; a request still owed a
        // response must first drain it before fetching from the new pc.
        if (redirect_valid) begin
            push          = 1'b0;
            fetch_pc_next = redirect_pc & ~XLEN'(3);
            case (state_reg)
                ST_REQ:   state_next = handshake ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_next = mem_resp_valid ? ST_REQ : ST_DRAIN;
                default:  state_next = mem_resp_valid ? ST_REQ : ST_DRAIN;
            endcase
        end
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push && !reset),
        .push_data ({resp_word, req_pc_reg}),
        .pop       (inst_valid && inst_ready),
        .flush     (redirect_valid),
        .head_data (head_data),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign inst_valid = !q_empty && !reset;
    assign inst       = reset ? 32'd0 : head_data[QW-1:XLEN];
    assign inst_pc    = reset ? '0 : head_data[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory model plus
// an epoch-tagged expected queue, and a directed XLEN=32 wrap-around check.
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset, mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [63:0] mem_req_addr, mem_resp_data, redirect_pc, inst_pc;
    logic        redirect_valid, inst_valid, inst_ready;
    logic [31:0] inst;

    logic        x_reset, x_req_valid, x_req_ready, x_resp_valid;
    logic [31:0] x_req_addr, x_rpc, x_inst_pc, x_inst;
    logic [63:0] x_resp_data;
    logic        x_redirect, x_inst_valid, x_inst_ready;

    int n_checks = 0;
    int n_fail   = 0;

    entry_t      sb[$];
    logic [63:0] exp_pc;
    int          epoch = 0;
    bit          out_busy = 0;
    logic [63:0] out_pc;
    int          out_epoch, out_cnt, mem_lat;
    bit          k_reset, k_ready, k_iready, k_redirect;
    logic [63:0] k_rpc;

    always #5 clock = ~clock;

    fetch_unit #(.XLEN(64), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(2)) dut32 (
        .clock(clock), .reset(x_reset),
        .mem_req_valid(x_req_valid), .mem_req_ready(x_req_ready),
        .mem_req_addr(x_req_addr), .mem_resp_valid(x_resp_valid),
        .mem_resp_data(x_resp_data), .redirect_valid(x_redirect),
        .redirect_pc(x_rpc), .inst_valid(x_inst_valid),
        .inst_ready(x_inst_ready), .inst(x_inst), .inst_pc(x_inst_pc)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == RST_PC) return 64'hAAAA_BBBB_1111_2222;
        return {a[31:0] ^ 32'h9ABC_DEF0, a[31:0] ^ 32'h1234_5678};
    endfunction

    function automatic bit pred_valid();
        return !k_reset && !out_busy && (sb.size() < DEPTH);
    endfunction

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step();
        bit          resp_now, ev;
        logic [63:0] w;
        entry_t      e;
        @(negedge clock);
        reset          = k_reset;
        redirect_valid = k_redirect;
        redirect_pc    = k_rpc;
        mem_req_ready  = k_ready;
        inst_ready     = k_iready;
        resp_now       = 1'b0;
        if (out_busy) begin
            out_cnt--;
            if (out_cnt == 0) resp_now = 1'b1;
        end
        mem_resp_valid = resp_now;
        mem_resp_data  = resp_now ? mem_word({out_pc[63:3], 3'b000}) : {$urandom, $urandom};
        #1;
        ev = pred_valid();
        check_val("req_valid", mem_req_valid, ev);
        if (ev) check_val("req_addr", mem_req_addr, {exp_pc[63:3], 3'b000});
        if (!k_reset && sb.size() > 0) begin
            check_val("inst_valid", inst_valid, 1);
            check_val("inst", inst, sb[0].inst);
            check_val("inst_pc", inst_pc, sb[0].pc);
        end else begin
            check_val("inst_valid", inst_valid, 0);
            check_val("inst_idle", inst, 0);
            check_val("inst_pc_idle", inst_pc, 0);
        end
        if (k_reset) begin
            if (resp_now) out_busy = 0;
            sb.delete();
            exp_pc = RST_PC;
            epoch++;
        end else begin
            if (k_iready && sb.size() > 0) begin
                e = sb.pop_front();
                $display("deliver pc=%h inst=%h", e.pc, e.inst);
            end
            if (resp_now) begin
                out_busy = 0;
                if (out_epoch == epoch && !k_redirect) begin
                    w = mem_word({out_pc[63:3], 3'b000});
                    sb.push_back('{inst: (out_pc[2] ? w[63:32] : w[31:0]), pc: out_pc});
                    exp_pc = out_pc + 64'd4;
                end
            end
            if (ev && k_ready) begin
                out_busy  = 1;
                out_pc    = exp_pc;
                out_epoch = epoch;
                out_cnt   = mem_lat;
            end
            if (k_redirect) begin
                sb.delete();
                exp_pc = k_rpc & ~64'd3;
                epoch++;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (out_busy && n < 50) begin step(); n++; end
        if (out_busy) check_val("idle_timeout", 0, 1);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!out_busy && n < 50) begin step(); n++; end
        if (!out_busy) check_val("busy_timeout", 0, 1);
    endtask

    task automatic wait_pred();
        int n = 0;
        while (!pred_valid() && n < 50) begin step(); n++; end
        if (!pred_valid()) check_val("req_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
        x_reset = 1; x_req_ready = 0; x_resp_valid = 0; x_resp_data = 0;
        x_redirect = 0; x_rpc = 0; x_inst_ready = 0;
        exp_pc = RST_PC;
        k_reset = 1; k_ready = 1; k_iready = 1; k_redirect = 0; k_rpc = 0; mem_lat = 1;

        // Reset release and first two instructions from the reset line
        repeat (3) step();
        k_reset = 0;
        repeat (12) step();

        // Consumer stall fills the queue; one pop frees one request
        k_iready = 0;
        repeat (20) step();
        k_iready = 1; step();
        k_iready = 0; repeat (6) step();
        k_iready = 1; repeat (8) step();

        // Redirect while waiting, response two cycles later
        mem_lat = 3;
        wait_idle(); wait_busy();
        k_rpc = 64'h8000_0102; k_redirect = 1; step();
        k_redirect = 0; mem_lat = 1;
        repeat (10) step();

        // Redirect in the same cycle as a response
        wait_idle(); wait_busy();
        k_rpc = 64'h8000_0180; k_redirect = 1; step();
        k_redirect = 0;
        repeat (8) step();

        // Redirect coinciding with a request handshake
        mem_lat = 2;
        wait_idle(); wait_pred();
        k_rpc = 64'h8000_0200; k_redirect = 1; step();
        k_redirect = 0;
        repeat (8) step();

        // Second redirect while draining
        mem_lat = 3;
        wait_idle(); wait_pred();
        k_rpc = 64'h8000_0300; k_redirect = 1; step();
        k_rpc = 64'h8000_0304; step();
        k_redirect = 0;
        repeat (10) step();

        // Reset while waiting, response lands during reset
        mem_lat = 2;
        wait_idle(); wait_busy();
        k_reset = 1; repeat (3) step();
        k_reset = 0; mem_lat = 1;
        repeat (6) step();

        // Random back-pressure, latency and redirects
        for (int i = 0; i < 400; i++) begin
            k_ready    = ($urandom_range(0, 3) != 0);
            k_iready   = ($urandom_range(0, 3) != 0);
            mem_lat    = $urandom_range(1, 3);
            k_redirect = ($urandom_range(0, 19) == 0);
            k_rpc      = {32'h0, 32'h8000_0000 | $urandom_range(0, 32'h0FFF)};
            step();
        end
        k_redirect = 0; k_ready = 1; k_iready = 1; mem_lat = 1;
        wait_idle();
        repeat (10) step();

        // XLEN=32: pc wraps from 0xFFFF_FFFC to 0
        @(negedge clock); x_reset = 1;
        @(negedge clock);
        x_reset = 0; x_req_ready = 1; x_inst_ready = 1;
        #1;
        check_val("x32_req_valid0", x_req_valid, 1);
        check_val("x32_addr0", x_req_addr, 32'hFFFF_FFF8);
        @(negedge clock);
        x_resp_valid = 1; x_resp_data = 64'h1357_9BDF_0246_8ACE;
        #1;
        check_val("x32_wait_valid", x_req_valid, 0);
        @(negedge clock);
        x_resp_valid = 0; x_req_ready = 0;
        #1;
        check_val("x32_req_valid1", x_req_valid, 1);
        check_val("x32_addr_wrap", x_req_addr, 32'h0000_0000);
        check_val("x32_inst_valid", x_inst_valid, 1);
        check_val("x32_inst", x_inst, 32'h1357_9BDF);
        check_val("x32_inst_pc", x_inst_pc, 32'hFFFF_FFFC);
        $display("x32 deliver pc=%h inst=%h", x_inst_pc, x_inst);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
